hls_deadlock_monitor_param: RTL and testbench

Parametrised dataflow deadlock monitor for one HLS dataflow region with NUM_PROC processes and NUM_AXIS AXI-stream block signals. Per-process AXIS blocking is derived from compile-time masks and optional child-region monitor outputs. A persistence filter requires the stall pattern to hold for HOLD_CYCLES consecutive cycles before it is reported. Adds a sticky flag, a per-process snapshot at detection, and a saturating event counter for debug readout. Sits beside the region instance; its block output feeds the parent region's monitor.

---
 rtl/hls_deadlock_pkg.sv | 17 +
 rtl/hls_deadlock_persist_filter.sv | 34 +++
 rtl/hls_deadlock_monitor_param.sv | 64 ++++++
 tb/tb_hls_deadlock_monitor_param.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/hls_deadlock_pkg.sv
// hls_deadlock_pkg: shared FSM state type and mask/counter helpers for the deadlock monitor
package hls_deadlock_pkg;
  localparam int MAX_AXIS = 64;
  localparam int MAX_MASK_W = 32 * MAX_AXIS;
  typedef enum logic [1:0] {IDLE, COUNT, BLOCKED} state_t;
  function automatic logic [MAX_AXIS-1:0] axis_row(input logic [MAX_MASK_W-1:0] mask, input int i, input int n);
    logic [MAX_AXIS-1:0] r;
    r = '0;
    for (int j = 0; j < n; j++) r[j] = mask[i*n+j];
    return r;
  endfunction
  function automatic logic [63:0] sat_inc(input logic [63:0] v, input int w);
    logic [63:0] top;
    top = (w >= 64) ? '1 : (64'(1) << w) - 64'(1);
    return (v == top) ? v : v + 64'(1);
  endfunction
endpackage

// File: rtl/hls_deadlock_persist_filter.sv
// hls_deadlock_persist_filter: reports cond only after it holds HOLD_CYCLES consecutive cycles
// ports: clock, reset (async, active-high), cond in; blocked (registered), enter_pulse (next edge enters BLOCKED) out
module hls_deadlock_persist_filter
  import hls_deadlock_pkg::*;
#(
  parameter int HOLD_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic cond,
  output logic blocked,
  output logic enter_pulse
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  state_t state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  // any drop of cond restarts from IDLE; HOLD_CYCLES==1 skips COUNT entirely
  always_comb begin
    state_nxt = !cond ? IDLE :
                (state == BLOCKED || HOLD_CYCLES == 1 ||
                 (state == COUNT && cnt == CW'(HOLD_CYCLES - 1))) ? BLOCKED : COUNT;
    cnt_nxt = !cond ? '0 : (state == IDLE) ? CW'(1) : (state == COUNT) ? cnt + CW'(1) : cnt;
    enter_pulse = (state_nxt == BLOCKED) && (state != BLOCKED);
    blocked = (state == BLOCKED);
  end
endmodule

// File: rtl/hls_deadlock_monitor_param.sv
// hls_deadlock_monitor_param: dataflow-region deadlock monitor with persistence filter and debug capture
// ports: clock, reset (async, active-high); axis_block_sigs, inst_idle_sigs, inst_block_sigs, child_block, clear in;
//        block (live), block_sticky, block_snapshot (ab at detection), event_count (saturating) out
module hls_deadlock_monitor_param
  import hls_deadlock_pkg::*;
#(
  parameter int NUM_PROC = 5,
  parameter int NUM_AXIS = 5,
  parameter logic [NUM_PROC*NUM_AXIS-1:0] AXIS_MASK = '0,
  parameter logic [NUM_PROC-1:0] CHILD_MASK = '0,
  parameter int HOLD_CYCLES = 16,
  parameter int EVT_W = 8
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_AXIS-1:0] axis_block_sigs,
  input  logic [NUM_PROC-1:0] inst_idle_sigs,
  input  logic [NUM_PROC-1:0] inst_block_sigs,
  input  logic [NUM_PROC-1:0] child_block,
  input  logic                clear,
  output logic                block,
  output logic                block_sticky,
  output logic [NUM_PROC-1:0] block_snapshot,
  output logic [EVT_W-1:0]    event_count
);
  logic [NUM_PROC-1:0] ab, stop;
  logic [MAX_AXIS-1:0] row;
  logic m, cond, enter;
  always_comb begin
    ab = '0;
    stop = '0;
    row = '0;
    m = 1'b0;
    for (int i = 0; i < NUM_PROC; i++) begin
      row = axis_row(MAX_MASK_W'(AXIS_MASK), i, NUM_AXIS);
      m = |(row & MAX_AXIS'(axis_block_sigs));
      ab[i] = CHILD_MASK[i] ? (child_block[i] & m) : m;
      stop[i] = inst_idle_sigs[i] | inst_block_sigs[i] | ab[i];
    end
    cond = (|ab) & (&stop);
  end
  hls_deadlock_persist_filter #(.HOLD_CYCLES(HOLD_CYCLES)) u_filter (
    .clock(clock),
    .reset(reset),
    .cond(cond),
    .blocked(block),
    .enter_pulse(enter)
  );
  // a detection on the same edge as clear wins: the count restarts at one
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      block_sticky <= 1'b0;
      block_snapshot <= '0;
      event_count <= '0;
    end else if (enter) begin
      block_sticky <= 1'b1;
      block_snapshot <= ab;
      event_count <= clear ? EVT_W'(1) : EVT_W'(sat_inc(64'(event_count), EVT_W));
    end else if (clear) begin
      block_sticky <= 1'b0;
      block_snapshot <= '0;
      event_count <= '0;
    end
endmodule

// File: tb/tb_hls_deadlock_monitor_param.sv
// tb_hls_deadlock_monitor_param: table-driven and sequence checks of the deadlock monitor
module tb_hls_deadlock_monitor_param;
  localparam logic [24:0] AM = 25'h0A0020;
  logic clock = 1'b0, reset = 1'b1, clear = 1'b0;
  logic [4:0] axis, idle, iblk, child;
  logic blk0, blk1, blk2, st0, st1, st2;
  logic [4:0] sn0, sn1, sn2;
  logic [1:0] ec0;
  logic [7:0] ec1, ec2;
  int pass = 0, total = 0;
  always #5 clock = ~clock;
  hls_deadlock_monitor_param #(.NUM_PROC(5), .NUM_AXIS(5), .AXIS_MASK(AM), .CHILD_MASK(5'b0),
    .HOLD_CYCLES(4), .EVT_W(2)) u0 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .child_block(child), .clear(clear), .block(blk0), .block_sticky(st0), .block_snapshot(sn0), .event_count(ec0));
  hls_deadlock_monitor_param #(.NUM_PROC(5), .NUM_AXIS(5), .AXIS_MASK(AM), .CHILD_MASK(5'b00010),
    .HOLD_CYCLES(4), .EVT_W(8)) u1 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .child_block(child), .clear(clear), .block(blk1), .block_sticky(st1), .block_snapshot(sn1), .event_count(ec1));
  hls_deadlock_monitor_param #(.NUM_PROC(5), .NUM_AXIS(5), .AXIS_MASK(AM), .CHILD_MASK(5'b0),
    .HOLD_CYCLES(1), .EVT_W(8)) u2 (
    .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle), .inst_block_sigs(iblk),
    .child_block(child), .clear(clear), .block(blk2), .block_sticky(st2), .block_snapshot(sn2), .event_count(ec2));
  typedef struct {
    logic [4:0] idle, iblk, axis, child;
    int cyc;
    logic b0, b1, b2;
    logic [4:0] snap0;
    logic [1:0] ec0;
  } vec_t;
  vec_t tv[8];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %0h expected %0h", n, a, e);
  endtask
  task automatic drive(input logic [4:0] i, input logic [4:0] b, input logic [4:0] a, input logic [4:0] c);
    idle = i;
    iblk = b;
    axis = a;
    child = c;
  endtask
  initial begin
    tv[0] = '{5'b11101, 5'b00000, 5'b00001, 5'b00000, 3, 1'b0, 1'b0, 1'b1, 5'b00000, 2'd0};
    tv[1] = '{5'b11101, 5'b00000, 5'b00001, 5'b00000, 12, 1'b1, 1'b0, 1'b1, 5'b00010, 2'd1};
    tv[2] = '{5'b11101, 5'b00000, 5'b00001, 5'b00010, 4, 1'b1, 1'b1, 1'b1, 5'b00010, 2'd2};
    tv[3] = '{5'b11111, 5'b00000, 5'b00000, 5'b00000, 6, 1'b0, 1'b0, 1'b0, 5'b00010, 2'd2};
    tv[4] = '{5'b10111, 5'b00000, 5'b10000, 5'b00000, 4, 1'b1, 1'b1, 1'b1, 5'b01000, 2'd3};
    tv[5] = '{5'b00111, 5'b11000, 5'b00100, 5'b00000, 4, 1'b1, 1'b1, 1'b1, 5'b01000, 2'd3};
    tv[6] = '{5'b00111, 5'b00000, 5'b00100, 5'b00000, 6, 1'b0, 1'b0, 1'b0, 5'b01000, 2'd3};
    tv[7] = '{5'b11101, 5'b00000, 5'b00010, 5'b00000, 6, 1'b0, 1'b0, 1'b0, 5'b01000, 2'd3};
    drive(5'b0, 5'b0, 5'b0, 5'b0);
    repeat (2) @(negedge clock);
    chk("reset_block", 32'(blk0), 32'(0));
    chk("reset_sticky", 32'(st0), 32'(0));
    chk("reset_snap", 32'(sn0), 32'(0));
    chk("reset_ec", 32'(ec0), 32'(0));
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      drive(tv[k].idle, tv[k].iblk, tv[k].axis, tv[k].child);
      repeat (tv[k].cyc) @(posedge clock);
      #1;
      chk($sformatf("v%0d_block0", k), 32'(blk0), 32'(tv[k].b0));
      chk($sformatf("v%0d_block1", k), 32'(blk1), 32'(tv[k].b1));
      chk($sformatf("v%0d_block2", k), 32'(blk2), 32'(tv[k].b2));
      chk($sformatf("v%0d_snap0", k), 32'(sn0), 32'(tv[k].snap0));
      chk($sformatf("v%0d_ec0", k), 32'(ec0), 32'(tv[k].ec0));
      chk($sformatf("v%0d_sticky0", k), 32'(st0), 32'(tv[k].ec0 != 0));
      @(negedge clock);
      drive(5'b0, 5'b0, 5'b0, 5'b0);
      @(posedge clock);
    end
    // a one-cycle drop restarts the count
    @(negedge clock);
    drive(5'b11101, 5'b0, 5'b00001, 5'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    drive(5'b0, 5'b0, 5'b0, 5'b0);
    @(posedge clock);
    #1;
    chk("drop_block0", 32'(blk0), 32'(0));
    chk("drop_block2", 32'(blk2), 32'(0));
    @(negedge clock);
    drive(5'b11101, 5'b0, 5'b00001, 5'b0);
    repeat (3) @(posedge clock);
    #1;
    chk("restart_3", 32'(blk0), 32'(0));
    @(posedge clock);
    #1;
    chk("restart_4", 32'(blk0), 32'(1));
    chk("restart_ec_sat", 32'(ec0), 32'(3));
    // asynchronous reset while blocked
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    chk("async_block", 32'(blk0), 32'(0));
    chk("async_sticky", 32'(st0), 32'(0));
    chk("async_ec", 32'(ec0), 32'(0));
    chk("async_snap", 32'(sn0), 32'(0));
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("redetect_3", 32'(blk0), 32'(0));
    @(posedge clock);
    #1;
    chk("redetect_4", 32'(blk0), 32'(1));
    chk("redetect_ec", 32'(ec0), 32'(1));
    // clear without a detection leaves block alone
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    chk("clear_sticky", 32'(st0), 32'(0));
    chk("clear_ec", 32'(ec0), 32'(0));
    chk("clear_snap", 32'(sn0), 32'(0));
    chk("clear_block", 32'(blk0), 32'(1));
    @(negedge clock);
    clear = 1'b0;
    // five detections saturate a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      drive(5'b0, 5'b0, 5'b0, 5'b0);
      @(negedge clock);
      drive(5'b11101, 5'b0, 5'b00001, 5'b0);
      repeat (4) @(posedge clock);
    end
    #1;
    chk("sat_ec", 32'(ec0), 32'(3));
    // clear coinciding with the sixth detection
    @(negedge clock);
    drive(5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clock);
    drive(5'b11101, 5'b0, 5'b00001, 5'b0);
    repeat (3) @(posedge clock);
    @(negedge clock);
    clear = 1'b1;
    @(posedge clock);
    #1;
    chk("clr_evt_ec", 32'(ec0), 32'(1));
    chk("clr_evt_sticky", 32'(st0), 32'(1));
    chk("clr_evt_snap", 32'(sn0), 32'(5'b00010));
    chk("clr_evt_block", 32'(blk0), 32'(1));
    @(negedge clock);
    clear = 1'b0;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
